// File: rtl/alu_pkg.sv
// alu_pkg: opcode map and scheduler state encoding shared with the ALU
package alu_pkg;
  localparam logic [7:0] OP_NOP = 8'd0;
  localparam logic [7:0] OP_ADD = 8'd1;
  localparam logic [7:0] OP_SUB = 8'd2;
  localparam logic [7:0] OP_MUL = 8'd3;
  localparam logic [7:0] OP_DIV = 8'd4;
  localparam logic [7:0] OP_MOD = 8'd5;
  localparam logic [7:0] OP_AND = 8'd6;
  localparam logic [7:0] OP_OR  = 8'd7;
  localparam logic [7:0] OP_XOR = 8'd8;
  typedef enum logic [2:0] {IDLE, EXEC, WAIT, RESP, REJECT} state_t;
  function automatic logic op_valid(input logic [7:0] op);
    return op >= OP_ADD && op <= OP_XOR;
  endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; history advances only on accept
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant
);
  logic last_grant;
  assign grant = &req ? ~last_grant : req[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last_grant <= 1'b1;
    else if (update) last_grant <= grant;
endmodule

// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler: shares one clocked ALU between two requesters, rejecting bad ops and /0
module alu_op_scheduler
  import alu_pkg::*;
#(
  parameter int W = 8,
  parameter int ALU_LATENCY = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [15:0]    req_op,
  input  logic [2*W-1:0] req_a,
  input  logic [2*W-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [W-1:0]   rsp_x,
  output logic [7:0]     rsp_flags,
  output logic           rsp_err,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [7:0]     alu_sel,
  input  logic [W-1:0]   alu_x,
  input  logic [7:0]     alu_flags
);
  state_t         state;
  logic           id;
  logic [2:0]     cnt;
  logic           grant;
  logic           accept;
  logic           g_ok;
  logic [7:0]     g_op;
  logic [W-1:0]   g_a;
  logic [W-1:0]   g_b;
  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .update (accept),
    .grant  (grant)
  );
  assign g_op = grant ? req_op[15:8] : req_op[7:0];
  assign g_a = grant ? req_a[2*W-1:W] : req_a[W-1:0];
  assign g_b = grant ? req_b[2*W-1:W] : req_b[W-1:0];
  assign req_ready = (rst_n && state == IDLE) ? (grant ? 2'b10 : 2'b01) & req_valid : 2'b00;
  assign accept = |(req_valid & req_ready);
  assign g_ok = op_valid(g_op) && !((g_op == OP_DIV || g_op == OP_MOD) && g_b == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      id        <= 1'b0;
      cnt       <= 3'd0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_x     <= '0;
      rsp_flags <= 8'd0;
      rsp_err   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= OP_NOP;
    end else begin
      case (state)
        IDLE: if (accept) begin
          id <= grant;
          if (g_ok) begin
            alu_a   <= g_a;
            alu_b   <= g_b;
            alu_sel <= g_op;
            cnt     <= ALU_LATENCY[2:0];
            state   <= EXEC;
          end else state <= REJECT;
        end
        EXEC: state <= WAIT;
        WAIT: begin
          cnt <= cnt - 3'd1;
          // capture lands ALU_LATENCY+1 edges after accept
          if (cnt == 3'd1) begin
            rsp_x     <= alu_x;
            rsp_flags <= alu_flags;
            rsp_err   <= 1'b0;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            alu_sel   <= OP_NOP;
            state     <= RESP;
          end
        end
        REJECT: begin
          rsp_x     <= '0;
          rsp_flags <= 8'd0;
          rsp_err   <= 1'b1;
          rsp_id    <= id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_op_scheduler.sv
// tb_alu_op_scheduler: directed and random checks against a behavioural ALU/arbitration model
module tb_alu_op_scheduler;
  localparam int W = 8;
  localparam int L = 1;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [15:0]  req_op = '0;
  logic [15:0]  req_a = '0;
  logic [15:0]  req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic         rsp_id;
  logic [7:0]   rsp_x;
  logic [7:0]   rsp_flags;
  logic         rsp_err;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic [7:0]   alu_sel;
  logic [7:0]   alu_x;
  logic [7:0]   alu_flags;
  logic [7:0]   px [L];
  logic [7:0]   pf [L];
  int           errors = 0;
  int           checks = 0;
  int           last_g = 1;
  alu_op_scheduler #(.W(W), .ALU_LATENCY(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_x     (rsp_x),
    .rsp_flags (rsp_flags),
    .rsp_err   (rsp_err),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_x     (alu_x),
    .alu_flags (alu_flags)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] ref_x(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    case (op)
      8'd1: r = ia + ib;
      8'd2: r = ia - ib;
      8'd3: r = ia * ib;
      8'd4: r = (ib != 0) ? ia / ib : 0;
      8'd5: r = (ib != 0) ? ia % ib : 0;
      8'd6: r = ia & ib;
      8'd7: r = ia | ib;
      8'd8: r = ia ^ ib;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction
  function automatic logic [7:0] ref_f(input logic [7:0] op, input logic [7:0] x);
    return {x == 8'd0, x[7], 2'b00, op[3:0]};
  endfunction
  // behavioural ALU: result appears L edges after its inputs change
  always @(posedge clk) begin
    px[0] <= ref_x(alu_sel, alu_a, alu_b);
    pf[0] <= ref_f(alu_sel, ref_x(alu_sel, alu_a, alu_b));
    for (int i = 1; i < L; i++) begin
      px[i] <= px[i-1];
      pf[i] <= pf[i-1];
    end
  end
  assign alu_x = px[L-1];
  assign alu_flags = pf[L-1];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic transact(input logic [1:0] v, input logic [7:0] o0, input logic [7:0] o1,
                          input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] b0, input logic [7:0] b1, input int bp);
    int g;
    int n;
    logic ok;
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] x;
    logic [7:0] f;
    g = (v == 2'b11) ? (last_g == 1 ? 0 : 1) : (v[1] ? 1 : 0);
    req_valid = v;
    req_op = {o1, o0};
    req_a = {a1, a0};
    req_b = {b1, b0};
    #1;
    chk("req_ready", 32'(req_ready), (g == 1) ? 32'd2 : 32'd1);
    step();
    last_g = g;
    req_valid = 2'b00;
    op = (g == 1) ? o1 : o0;
    a = (g == 1) ? a1 : a0;
    b = (g == 1) ? b1 : b0;
    ok = (op >= 8'd1 && op <= 8'd8) && !((op == 8'd4 || op == 8'd5) && b == 8'd0);
    x = ok ? ref_x(op, a, b) : 8'd0;
    f = ok ? ref_f(op, x) : 8'd0;
    chk("ready_busy", 32'(req_ready), 32'd0);
    if (ok) chk("alu_ab", {16'd0, alu_a, alu_b}, {16'd0, a, b});
    n = 0;
    while (!rsp_valid && n < 20) begin
      chk("alu_sel_hold", 32'(alu_sel), ok ? 32'(op) : 32'd0);
      step();
      n++;
    end
    chk("latency", n, ok ? L + 1 : 1);
    chk("rsp_id", 32'(rsp_id), 32'(g));
    chk("rsp_x", 32'(rsp_x), 32'(x));
    chk("rsp_flags", 32'(rsp_flags), 32'(f));
    chk("rsp_err", 32'(rsp_err), 32'(!ok));
    chk("alu_sel_idle", 32'(alu_sel), 32'd0);
    repeat (bp) begin
      step();
      chk("rsp_hold", {11'd0, rsp_valid, rsp_id, rsp_err, rsp_flags, rsp_x, req_ready},
          {11'd0, 1'b1, g[0], !ok, f, x, 2'b00});
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask
  initial begin
    #3;
    chk("reset_outs", {7'd0, req_ready, rsp_valid, rsp_id, rsp_err, rsp_x, rsp_flags, alu_sel},
        32'd0);
    chk("reset_alu_ab", {16'd0, alu_a, alu_b}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    transact(2'b01, 8'd1, 8'd0, 8'd5, 8'd0, 8'd3, 8'd0, 0);
    transact(2'b11, 8'd2, 8'd3, 8'd5, 8'd2, 8'd3, 8'd4, 1);
    transact(2'b10, 8'd2, 8'd3, 8'd5, 8'd2, 8'd3, 8'd4, 0);
    transact(2'b11, 8'd6, 8'd1, 8'd12, 8'd1, 8'd10, 8'd1, 0);
    transact(2'b10, 8'd0, 8'd4, 8'd0, 8'd6, 8'd0, 8'd0, 0);
    transact(2'b10, 8'd0, 8'd5, 8'd0, 8'd6, 8'd0, 8'd0, 2);
    transact(2'b10, 8'd0, 8'd4, 8'd0, 8'd6, 8'd0, 8'd2, 0);
    transact(2'b01, 8'h09, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 0);
    transact(2'b01, 8'd8, 8'd0, 8'hCC, 8'd0, 8'hAA, 8'd0, 0);
    transact(2'b01, 8'd6, 8'd0, 8'hCC, 8'd0, 8'hAA, 8'd0, 0);
    transact(2'b01, 8'd7, 8'd0, 8'hCC, 8'd0, 8'hAA, 8'd0, 6);
    // reset while the op sits in WAIT: no response must ever appear
    req_valid = 2'b01;
    req_op = {8'd0, 8'd1};
    req_a = {8'd0, 8'd9};
    req_b = {8'd0, 8'd9};
    step();
    req_valid = 2'b00;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", {29'd0, rsp_valid, alu_sel != 8'd0, req_ready != 2'b00}, 32'd0);
    last_g = 1;
    repeat (3) begin
      step();
      chk("rst_quiet", {24'd0, alu_sel | {7'd0, rsp_valid}}, 32'd0);
    end
    rst_n = 1'b1;
    step();
    chk("post_rst_quiet", 32'(rsp_valid), 32'd0);
    transact(2'b10, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 0);
    for (int k = 0; k < 30; k++) begin
      transact(2'($urandom_range(1, 3)), 8'($urandom_range(0, 10)), 8'($urandom_range(0, 10)),
               8'($urandom), 8'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
               ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
               int'($urandom_range(0, 3)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
